tx_filt_seq: RTL and testbench

- Time-multiplexed controller and datapath for the 21-tap symmetric pulse-shaping TX filter. One pre-adder and one 18x18 multiplier are shared across all coefficient pairs.
- Accepts one input sample per valid/ready handshake, sequences NCOEF multiply-accumulate cycles, and presents the result on a valid/ready output.
- Owns the coefficient table and allows runtime reload through a config port while idle.

---
 rtl/tx_filt_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_tx_filt_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_filt_seq.sv
// tx_filt_seq -- time-multiplexed symmetric FIR for TX pulse shaping.
//
// One pre-adder and one 18x18 multiplier are shared across the NCOEF
// coefficient pairs. A sample is accepted over a valid/ready handshake.
// The block then runs NCOEF multiply-accumulate cycles and presents the
// result on a valid/ready output. The coefficient table can be reloaded
// through the cfg_* port while the block is idle.
//
// Optional feature: define TX_FILT_SAT_EN to saturate the result to the
// 18-bit range and report clamping on ovf. When it is undefined, the result
// wraps and ovf is held at 0.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   x_in       input sample, 1s17
//   in_valid   x_in valid
//   in_ready   block can accept a sample this cycle
//   y          filter output, 18-bit two's complement
//   out_valid  y valid
//   out_ready  downstream accepts y
//   cfg_we     coefficient write strobe (honoured only in IDLE)
//   cfg_addr   coefficient index
//   cfg_data   coefficient value, 0s18 signed
//   busy       high in MAC or OUT state
//   ovf        saturation flag, registered with y
module tx_filt_seq #(
  parameter  int NTAPS = 21,
  parameter  int ACC_W = 22,
  localparam int NCOEF = (NTAPS + 1) / 2,
  localparam int AW    = $clog2(NCOEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [17:0] x_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [17:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic signed [17:0] cfg_data,
  output logic               busy,
  output logic               ovf
);

  localparam int XW = $clog2(NTAPS);

  // Default table for the 21-tap shaper; any other length starts at zero.
  function automatic logic signed [17:0] coef_default(input int idx);
    logic signed [17:0] v;
    v = '0;
    if (NTAPS == 21) begin
      case (idx)
        0:       v = 18'sd67;
        1:       v = 18'sd1261;
        2:       v = 18'sd1793;
        3:       v = -18'sd81;
        4:       v = -18'sd4311;
        5:       v = -18'sd7524;
        6:       v = -18'sd4326;
        7:       v = 18'sd8596;
        8:       v = 18'sd28599;
        9:       v = 18'sd47153;
        10:      v = 18'sd54721;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [AW-1:0]             r_k;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [17:0]        r_y;
  logic                      r_out_valid;
  logic                      r_ovf;

  logic signed [17:0]        w_x [NTAPS];
  logic signed [17:0]        w_b [NCOEF];
  logic                      w_accept;
  logic                      w_cfg_wr;
  logic                      w_last;
  logic [XW-1:0]             w_mirror;
  logic signed [17:0]        w_pair;
  logic signed [17:0]        w_coef;
  logic signed [35:0]        w_prod;
  logic signed [ACC_W-1:0]   w_term;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic signed [17:0]        w_y_final;
  logic                      w_sat;
  logic                      w_unused;

  assign in_ready  = (r_state == S_IDLE) & ~cfg_we & ~reset;
  assign busy      = (r_state != S_IDLE);
  assign y         = r_y;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;

  assign w_accept = in_valid & in_ready;
  // Extra address bit so the bound check still works when NCOEF is a power of two.
  assign w_cfg_wr = (r_state == S_IDLE) & cfg_we &
                    ({1'b0, cfg_addr} < (AW + 1)'(NCOEF));

  // Delay line: shifts only on an accepted sample; the new sample enters halved.
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
    logic signed [17:0] r_tap;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (reset)
          r_tap <= '0;
        else if (w_accept)
          r_tap <= {x_in[17], x_in[17:1]};
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (reset)
          r_tap <= '0;
        else if (w_accept)
          r_tap <= w_x[gi-1];
      end
    end
    assign w_x[gi] = r_tap;
  end

  // Coefficient table, reloaded to defaults on reset.
  for (genvar gi = 0; gi < NCOEF; gi++) begin : g_coef
    logic signed [17:0] r_coef;
    always_ff @(posedge clk) begin
      if (reset)
        r_coef <= coef_default(gi);
      else if (w_cfg_wr && (cfg_addr == AW'(gi)))
        r_coef <= cfg_data;
    end
    assign w_b[gi] = r_coef;
  end

  // Shared pre-adder and multiplier. The centre tap has no partner.
  assign w_last   = (r_k == AW'(NCOEF - 1));
  assign w_mirror = XW'(NTAPS - 1) - XW'(r_k);

  always_comb begin
    w_pair = '0;
    if (w_last)
      w_pair = w_x[NCOEF-1];
    else
      w_pair = w_x[XW'(r_k)] + w_x[w_mirror];
    w_coef = w_b[r_k];
  end

  assign w_prod    = 36'(w_pair) * 36'(w_coef);
  assign w_term    = {{(ACC_W - 18){w_prod[34]}}, w_prod[34:17]};
  assign w_acc_sum = r_acc + w_term;

`ifdef TX_FILT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(131071);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(131072);

  always_comb begin
    w_sat     = 1'b0;
    w_y_final = w_acc_sum[17:0];
    if (w_acc_sum > SAT_MAX) begin
      w_sat     = 1'b1;
      w_y_final = 18'h1FFFF;
    end else if (w_acc_sum < SAT_MIN) begin
      w_sat     = 1'b1;
      w_y_final = 18'h20000;
    end
  end
`else
  assign w_sat     = 1'b0;
  assign w_y_final = w_acc_sum[17:0];
`endif

  // The product keeps only bits 34:17, and the input LSB is dropped by the halving.
  assign w_unused = ^{w_prod[35], w_prod[16:0], x_in[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_k     <= '0;
            r_acc   <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_sum;
          r_k   <= r_k + 1'b1;
          // The final value uses the last product directly, so y is ready after NCOEF cycles.
          if (w_last) begin
            r_y         <= w_y_final;
            r_ovf       <= w_sat;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_filt_seq.sv
module tb_tx_filt_seq;
  localparam int NTAPS = 21;
  localparam int NCOEF = 11;
  localparam int ACC_W = 22;
  localparam int AW    = 4;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic [17:0]   x_in      = '0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [17:0]   y;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          cfg_we    = 1'b0;
  logic [AW-1:0] cfg_addr  = '0;
  logic [17:0]   cfg_data  = '0;
  logic          busy;
  logic          ovf;

  tx_filt_seq dut (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

  typedef struct { longint yv; longint ov; int cy; } exp_t;
  exp_t   sb[$];
  longint got_y[$];
  longint got_ovf[$];
  int     acc_cyc[$];

  longint hist [NTAPS];
  longint coef [NCOEF];
  longint defc [NCOEF] = '{67, 1261, 1793, -81, -4311, -7524, -4326, 8596, 28599, 47153, 54721};

  function automatic void check(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic longint wrapn(longint v, int n);
    longint m;
    m = v & ((64'sd1 <<< n) - 1);
    if (m >= (64'sd1 <<< (n - 1))) m = m - (64'sd1 <<< n);
    return m;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NTAPS; i++) hist[i] = 0;
    for (int i = 0; i < NCOEF; i++) coef[i] = defc[i];
  endfunction

  // Reference: y = sum over coefficient pairs of truncated (pair * b) / 2^17.
  function automatic void model_accept(longint s, int cy);
    longint acc, pair, term, yv, ov;
    exp_t e;
    for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s >>> 1;
    acc = 0;
    for (int k = 0; k < NCOEF; k++) begin
      if (k == NCOEF - 1) pair = hist[k];
      else                pair = wrapn(hist[k] + hist[NTAPS-1-k], 18);
      term = wrapn((pair * coef[k]) >>> 17, 18);
      acc  = wrapn(acc + term, ACC_W);
    end
`ifdef TX_FILT_SAT_EN
    if (acc > 131071)       begin yv = 131071;  ov = 1; end
    else if (acc < -131072) begin yv = -131072; ov = 1; end
    else                    begin yv = acc;     ov = 0; end
`else
    yv = wrapn(acc, 18);
    ov = 0;
`endif
    e.yv = yv; e.ov = ov; e.cy = cy;
    sb.push_back(e);
  endfunction

  // out_ready driver, changes 2 time units after each rising edge
  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_mode == 2) out_ready = ($urandom_range(0, 1) == 1);
    else               out_ready = (rdy_mode == 1);
  end

  // Monitor: pops the scoreboard on each output handshake
  bit     ov_prev = 1'b0;
  longint y_prev  = 0;
  always @(negedge clk) begin
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (!ov_prev) begin
          check("pending_exp", longint'(sb.size() > 0), 1);
          if (sb.size() > 0) check("latency", longint'(cyc - sb[0].cy), NCOEF);
        end else begin
          check("y_hold", $signed(y), y_prev);
        end
        if (out_ready && sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("y", $signed(y), e.yv);
          check("ovf", longint'(ovf), e.ov);
          got_y.push_back($signed(y));
          got_ovf.push_back(longint'(ovf));
        end
      end
      ov_prev = out_valid && !out_ready;
      y_prev  = $signed(y);
    end
  end

  task automatic send(input int s);
    bit ok;
    ok = 1'b0;
    x_in = 18'(s);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("send_timeout", longint'(ok), 1);
    if (ok) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_accept(longint'(s), cyc);
      acc_cyc.push_back(cyc);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin ok = 1'b1; break; end
    end
    check("idle_timeout", longint'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  // Call only while the DUT is idle.
  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = 18'(data);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (addr < NCOEF) coef[addr] = longint'(data);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_y", $signed(y), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // Impulse with default coefficients and out_ready high
    rdy_mode = 1;
    got_y.delete();
    acc_cyc.delete();
    send(131071);
    for (int i = 0; i < 20; i++) send(0);
    wait_idle();
    check("impulse_cnt", longint'(got_y.size()), 21);
    if (got_y.size() >= 2) begin
      check("impulse_y0", got_y[0], 33);
      check("impulse_y1", got_y[1], 630);
    end
    if (acc_cyc.size() >= 2) check("min_interval", longint'(acc_cyc[1] - acc_cyc[0]), NCOEF + 2);

    // Coefficient reload, out-of-range write ignored, write alongside in_valid
    cfg_write(0, 32768);
    for (int a = 1; a < NCOEF; a++) cfg_write(a, 0);
    cfg_write(12, 5555);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 18'(65536);
    x_in = 18'(40000); in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_cfg", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    coef[0] = 65536;
    send(40000);
    wait_idle();
    if (got_y.size() > 0) check("reload_y", got_y[$], 10000);

    // Backpressure
    rdy_mode = 0;
    send(-77777);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (out_valid) begin seen = 1'b1; break; end
      end
      check("bp_valid_seen", longint'(seen), 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_busy", longint'(busy), 1);
      check("bp_valid", longint'(out_valid), 1);
    end
    rdy_mode = 1;
    @(posedge clk);
    @(negedge clk);
    check("bp_valid_hold", longint'(out_valid), 1);
    @(posedge clk);
    @(negedge clk);
    check("bp_valid_fall", longint'(out_valid), 0);
    check("bp_ready_back", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // Randomized traffic with occasional idle reloads and random out_ready
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        cfg_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 262143)) - 131072);
      end
      send(int'($urandom_range(0, 262143)) - 131072);
    end
    wait_idle();
    rdy_mode = 1;

    // Config write during MAC must be ignored
    do_reset();
    send(1234);
    @(posedge clk);
    @(posedge clk);
    #1;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = '0;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    wait_idle();
    for (int i = 0; i < 20; i++) send(0);
    send(131071);
    wait_idle();
    if (got_y.size() > 0) check("busy_cfg_y", got_y[$], 33);

    // Overflow
    for (int a = 0; a < NCOEF; a++) cfg_write(a, 131071);
    for (int i = 0; i < 21; i++) send(131071);
    wait_idle();
`ifdef TX_FILT_SAT_EN
    if (got_y.size() > 0) check("ovf_y", got_y[$], 131071);
    if (got_ovf.size() > 0) check("ovf_flag", got_ovf[$], 1);
`else
    if (got_y.size() > 0) check("ovf_y", got_y[$], 65504);
    if (got_ovf.size() > 0) check("ovf_flag", got_ovf[$], 0);
`endif

    // Reset in the middle of MAC (k = 5)
    send(99999);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_busy", longint'(busy), 0);
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    send(131071);
    wait_idle();
    if (got_y.size() > 0) check("mid_rst_y", got_y[$], 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
